key_note_arbiter: RTL and testbench

KEY_NOTE_ARBITER -- requirements
Module: key_note_arbiter

---
 rtl/key_note_arbiter.sv | 122 ++++++++++++
 tb/tb_key_note_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/key_note_arbiter.sv
// Monophonic key-to-note arbiter: lowest-index press wins, legato fallback, timed release.
// Optional sustain pedal input is enabled by defining SUSTAIN_ARB_EN.
module key_note_arbiter #(
    parameter int unsigned NUM_KEYS    = 8,
    parameter int unsigned RELEASE_CYC = 1000000,
    localparam int unsigned IDX_W      = $clog2(NUM_KEYS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] key_level,
    input  logic [NUM_KEYS-1:0] key_press,
`ifdef SUSTAIN_ARB_EN
    input  logic                sustain,
`endif
    output logic [IDX_W-1:0]    note,
    output logic                gate,
    output logic                trig
);

    localparam logic [19:0] RELOAD = 20'(RELEASE_CYC - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PLAY    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   note_nxt;
    logic               gate_nxt;
    logic               trig_nxt;
    logic [19:0]        cnt, cnt_nxt;
    logic               any_press;
    logic               any_held;
    logic               sustain_hold;

`ifdef SUSTAIN_ARB_EN
    assign sustain_hold = sustain;
`else
    assign sustain_hold = 1'b0;
`endif

    assign any_press = |key_press;
    assign any_held  = |key_level;

    function automatic logic [IDX_W-1:0] lowest_idx(input logic [NUM_KEYS-1:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
        // Scan downward so the final assignment is the lowest set bit.
        for (int unsigned i = NUM_KEYS; i > 0; i--) begin
            if (v[i-1]) r = IDX_W'(i - 1);
        end
        return r;
    endfunction

    always_comb begin
        state_nxt = state;
        note_nxt  = note;
        gate_nxt  = gate;
        trig_nxt  = 1'b0;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                gate_nxt = 1'b0;
                if (any_press) begin
                    note_nxt  = lowest_idx(key_press);
                    trig_nxt  = 1'b1;
                    gate_nxt  = 1'b1;
                    state_nxt = PLAY;
                end
            end
            PLAY: begin
                gate_nxt = 1'b1;
                if (any_press) begin
                    note_nxt = lowest_idx(key_press);
                    trig_nxt = 1'b1;
                end else if (!key_level[note]) begin
                    if (any_held) begin
                        note_nxt = lowest_idx(key_level);
                    end else if (!sustain_hold) begin
                        cnt_nxt   = RELOAD;
                        state_nxt = RELEASE;
                    end
                end
            end
            RELEASE: begin
                gate_nxt = 1'b1;
                if (any_press) begin
                    note_nxt  = lowest_idx(key_press);
                    trig_nxt  = 1'b1;
                    state_nxt = PLAY;
                end else if (cnt == '0) begin
                    gate_nxt  = 1'b0;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - 20'd1;
                end
            end
            default: begin
                gate_nxt  = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            note  <= '0;
            gate  <= 1'b0;
            trig  <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            note  <= note_nxt;
            gate  <= gate_nxt;
            trig  <= trig_nxt;
            cnt   <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_key_note_arbiter.sv
// Directed self-checking bench for key_note_arbiter (NUM_KEYS=8, RELEASE_CYC=4).
module tb_key_note_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] key_level = '0;
    logic [7:0] key_press = '0;
`ifdef SUSTAIN_ARB_EN
    logic       sustain = 1'b0;
`endif
    logic [2:0] note;
    logic       gate;
    logic       trig;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    key_note_arbiter #(.NUM_KEYS(8), .RELEASE_CYC(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_level (key_level),
        .key_press (key_press),
`ifdef SUSTAIN_ARB_EN
        .sustain   (sustain),
`endif
        .note      (note),
        .gate      (gate),
        .trig      (trig)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] lvl, input logic [7:0] prs);
        key_level = lvl;
        key_press = prs;
    endtask

    task automatic do_reset();
        drive(8'h00, 8'h00);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(8'h00, 8'h00);
        step();
        n_cmp++; if (note !== 3'd0) begin n_err++; $display("FAIL reset_note got=%0d exp=0", note); end
        n_cmp++; if (gate !== 1'b0) begin n_err++; $display("FAIL reset_gate got=%b exp=0", gate); end
        n_cmp++; if (trig !== 1'b0) begin n_err++; $display("FAIL reset_trig got=%b exp=0", trig); end
        rst_n = 1'b1;
        step();
        drive(8'h10, 8'h00);
        step();
        n_cmp++; if (gate !== 1'b0) begin n_err++; $display("FAIL idle_held_no_press gate got=%b exp=0", gate); end
    endtask

    task automatic test_single_press();
        do_reset();
        drive(8'h08, 8'h08);
        step();
        n_cmp++; if (note !== 3'd3) begin n_err++; $display("FAIL press3_note got=%0d exp=3", note); end
        n_cmp++; if (gate !== 1'b1) begin n_err++; $display("FAIL press3_gate got=%b exp=1", gate); end
        n_cmp++; if (trig !== 1'b1) begin n_err++; $display("FAIL press3_trig got=%b exp=1", trig); end
        drive(8'h08, 8'h00);
        step();
        n_cmp++; if (trig !== 1'b0) begin n_err++; $display("FAIL press3_trig_one_cycle got=%b exp=0", trig); end
        drive(8'h00, 8'h00);
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++; if (gate !== 1'b1) begin n_err++; $display("FAIL release_hold[%0d] gate got=%b exp=1", i, gate); end
        end
        step();
        n_cmp++; if (gate !== 1'b0) begin n_err++; $display("FAIL release_end gate got=%b exp=0", gate); end
        n_cmp++; if (note !== 3'd3) begin n_err++; $display("FAIL idle_note_hold got=%0d exp=3", note); end
        n_cmp++; if (trig !== 1'b0) begin n_err++; $display("FAIL release_end trig got=%b exp=0", trig); end
    endtask

    task automatic test_legato();
        do_reset();
        drive(8'h08, 8'h08);
        step();
        drive(8'h08, 8'h00);
        step();
        drive(8'h28, 8'h20);
        step();
        n_cmp++; if (note !== 3'd5 || trig !== 1'b1) begin n_err++; $display("FAIL legato_press5 note=%0d trig=%b exp note=5 trig=1", note, trig); end
        drive(8'h28, 8'h00);
        step();
        drive(8'h08, 8'h00);
        step();
        n_cmp++; if (note !== 3'd3 || trig !== 1'b0 || gate !== 1'b1) begin
            n_err++; $display("FAIL legato_back note=%0d trig=%b gate=%b exp note=3 trig=0 gate=1", note, trig, gate);
        end
        drive(8'h00, 8'h00);
        for (int i = 0; i < 4; i++) step();
        n_cmp++; if (gate !== 1'b1) begin n_err++; $display("FAIL legato_release_last gate got=%b exp=1", gate); end
        step();
        n_cmp++; if (gate !== 1'b0) begin n_err++; $display("FAIL legato_release_done gate got=%b exp=0", gate); end
    endtask

    task automatic test_multi_press_retrigger();
        do_reset();
        drive(8'h24, 8'h24);
        step();
        n_cmp++; if (note !== 3'd2 || trig !== 1'b1) begin n_err++; $display("FAIL multi_press note=%0d trig=%b exp note=2 trig=1", note, trig); end
        drive(8'h00, 8'h00);
        for (int i = 0; i < 4; i++) step();
        drive(8'h40, 8'h40);
        step();
        n_cmp++; if (note !== 3'd6 || trig !== 1'b1 || gate !== 1'b1) begin
            n_err++; $display("FAIL release_retrig note=%0d trig=%b gate=%b exp note=6 trig=1 gate=1", note, trig, gate);
        end
        drive(8'h40, 8'h00);
        for (int i = 0; i < 6; i++) step();
        n_cmp++; if (gate !== 1'b1 || note !== 3'd6 || trig !== 1'b0) begin
            n_err++; $display("FAIL retrig_stays_play gate=%b note=%0d trig=%b exp gate=1 note=6 trig=0", gate, note, trig);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        drive(8'h02, 8'h02);
        step();
        drive(8'h12, 8'h10);
        step();
        n_cmp++; if (note !== 3'd4 || trig !== 1'b1) begin n_err++; $display("FAIL b2b_second note=%0d trig=%b exp note=4 trig=1", note, trig); end
        drive(8'h12, 8'h00);
        step();
        drive(8'h12, 8'h10);
        step();
        n_cmp++; if (note !== 3'd4 || trig !== 1'b1) begin n_err++; $display("FAIL repress_same note=%0d trig=%b exp note=4 trig=1", note, trig); end
        drive(8'h80, 8'h80);
        step();
        n_cmp++; if (note !== 3'd7 || trig !== 1'b1) begin n_err++; $display("FAIL press_and_release note=%0d trig=%b exp note=7 trig=1", note, trig); end
        drive(8'h80, 8'h00);
        step();
        n_cmp++; if (trig !== 1'b0 || note !== 3'd7) begin n_err++; $display("FAIL b2b_quiet note=%0d trig=%b exp note=7 trig=0", note, trig); end
    endtask

    task automatic test_reset_mid_play();
        do_reset();
        drive(8'h08, 8'h08);
        step();
        drive(8'h08, 8'h00);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (gate !== 1'b0 || trig !== 1'b0 || note !== 3'd0) begin
            n_err++; $display("FAIL async_reset_play gate=%b trig=%b note=%0d exp 0/0/0", gate, trig, note);
        end
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step();
        n_cmp++; if (gate !== 1'b0 || trig !== 1'b0) begin n_err++; $display("FAIL held_after_reset gate=%b trig=%b exp 0/0", gate, trig); end
        drive(8'h08, 8'h08);
        step();
        drive(8'h00, 8'h00);
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (gate !== 1'b0 || trig !== 1'b0) begin n_err++; $display("FAIL async_reset_release gate=%b trig=%b exp 0/0", gate, trig); end
        step();
        rst_n = 1'b1;
        step();
    endtask

`ifdef SUSTAIN_ARB_EN
    task automatic test_sustain();
        do_reset();
        sustain = 1'b1;
        drive(8'h02, 8'h02);
        step();
        drive(8'h00, 8'h00);
        for (int i = 0; i < 6; i++) step();
        n_cmp++; if (gate !== 1'b1 || note !== 3'd1) begin n_err++; $display("FAIL sustain_hold gate=%b note=%0d exp gate=1 note=1", gate, note); end
        sustain = 1'b0;
        for (int i = 0; i < 4; i++) step();
        n_cmp++; if (gate !== 1'b1) begin n_err++; $display("FAIL sustain_release_last gate=%b exp=1", gate); end
        step();
        n_cmp++; if (gate !== 1'b0) begin n_err++; $display("FAIL sustain_release_done gate=%b exp=0", gate); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_press();
        test_legato();
        test_multi_press_retrigger();
        test_back_to_back();
        test_reset_mid_play();
`ifdef SUSTAIN_ARB_EN
        test_sustain();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
